// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM controller: state encoding, menu codes,
// the fixed account table and balance arithmetic helpers.
package atm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MENU = 1'b1
  } state_t;

  typedef logic [10:0] bal_t;

  localparam int NUM_ACCOUNTS = 4;

  localparam logic [2:0] MENU_BALANCE               = 3'd3;
  localparam logic [2:0] MENU_WITHDRAW              = 3'd4;
  localparam logic [2:0] MENU_WITHDRAW_SHOW_BALANCE = 3'd5;
  localparam logic [2:0] MENU_TRANSACTION           = 3'd6;
  localparam logic [2:0] MENU_DEPOSIT               = 3'd7;

  localparam logic [11:0] MAX_BALANCE = 12'd2047;

  // Entry i lives in slice [i]; entry 0 is the lowest slice.
  localparam logic [NUM_ACCOUNTS-1:0][11:0] ACC_NUMBERS =
    {12'd3050, 12'd2419, 12'd2816, 12'd2178};
  localparam logic [NUM_ACCOUNTS-1:0][3:0] ACC_PINS =
    {4'd3, 4'd9, 4'd6, 4'd4};

  // True when a + b still fits in an 11-bit balance (sum taken in 12 bits).
  function automatic logic add_fits(input bal_t a, input bal_t b);
    logic [11:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    return (sum_s <= MAX_BALANCE);
  endfunction

  // True when amt can be taken from bal without going below zero.
  function automatic logic debit_ok(input bal_t bal, input bal_t amt);
    return ({1'b0, amt} <= {1'b0, bal});
  endfunction

endpackage

// File: rtl/atm_acct_lookup.sv
// Combinational account-number lookup: reports whether the number is in the
// fixed table and, if so, its 2-bit index.
module atm_acct_lookup
  import atm_pkg::*;
(
  input  logic [11:0] acc_number,
  output logic        found,
  output logic [1:0]  idx
);

  // Linear match against the fixed table; first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (!found && (acc_number == ACC_NUMBERS[i])) begin
        found = 1'b1;
        idx   = 2'(i);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/atm.sv
// ATM controller top: login FSM, per-account balance registers and menu datapath.
// Optional feature: define ATM_TRANSFER_EN to build the account-to-account transfer.
module atm
  import atm_pkg::*;
#(
  parameter bal_t INIT_BALANCE = 11'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exit,
  input  logic [11:0] accNumber,
  input  logic [3:0]  pin,
  input  logic [11:0] destinationAccNumber,
  input  logic [2:0]  menuOption,
  input  logic [10:0] amount,
  output logic        error,
  output logic [10:0] balance
);

  state_t                         state_r, state_s;
  logic [1:0]                     idx_r, idx_s;
  logic [NUM_ACCOUNTS-1:0][10:0]  bal_r, bal_s;
  logic                           error_r, error_s;
  bal_t                           balance_r, balance_s;

  logic                           login_found_s;
  logic [1:0]                     login_idx_s;
  bal_t                           cur_bal_s;

  atm_acct_lookup u_login_lookup (
    .acc_number (accNumber),
    .found      (login_found_s),
    .idx        (login_idx_s)
  );

`ifdef ATM_TRANSFER_EN
  logic                           dst_found_s;
  logic [1:0]                     dst_idx_s;
  bal_t                           dst_bal_s;

  atm_acct_lookup u_dst_lookup (
    .acc_number (destinationAccNumber),
    .found      (dst_found_s),
    .idx        (dst_idx_s)
  );

  assign dst_bal_s = bal_r[dst_idx_s];
`else
  logic unused_dst_s;
  assign unused_dst_s = ^destinationAccNumber;
`endif

  assign cur_bal_s = bal_r[idx_r];

  // Next-state, table update and output computation for one edge.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    bal_s     = bal_r;
    error_s   = error_r;
    balance_s = balance_r;

    case (state_r)
      ST_IDLE: begin
        balance_s = 11'd0;
        if (login_found_s && (pin == ACC_PINS[login_idx_s])) begin
          state_s = ST_MENU;
          idx_s   = login_idx_s;
          error_s = 1'b0;
        end else begin
          error_s = 1'b1;
        end
      end

      ST_MENU: begin
        if (exit) begin
          state_s   = ST_IDLE;
          balance_s = 11'd0;
          error_s   = 1'b0;
        end else begin
          case (menuOption)
            MENU_BALANCE: begin
              balance_s = cur_bal_s;
              error_s   = 1'b0;
            end
            MENU_WITHDRAW, MENU_WITHDRAW_SHOW_BALANCE: begin
              if (debit_ok(cur_bal_s, amount)) begin
                bal_s[idx_r] = cur_bal_s - amount;
                error_s      = 1'b0;
                if (menuOption == MENU_WITHDRAW_SHOW_BALANCE) begin
                  balance_s = cur_bal_s - amount;
                end else begin
                  balance_s = balance_r;
                end
              end else begin
                error_s = 1'b1;
              end
            end
            MENU_TRANSACTION: begin
`ifdef ATM_TRANSFER_EN
              if (!dst_found_s || (dst_idx_s == idx_r) ||
                  !debit_ok(cur_bal_s, amount) || !add_fits(dst_bal_s, amount)) begin
                error_s = 1'b1;
              end else begin
                bal_s[idx_r]     = cur_bal_s - amount;
                bal_s[dst_idx_s] = dst_bal_s + amount;
                error_s          = 1'b0;
              end
`else
              error_s = 1'b1;
`endif
            end
            MENU_DEPOSIT: begin
              if (add_fits(cur_bal_s, amount)) begin
                bal_s[idx_r] = cur_bal_s + amount;
                error_s      = 1'b0;
              end else begin
                error_s = 1'b1;
              end
            end
            default: begin
              error_s = 1'b0;
            end
          endcase
        end
      end

      default: begin
        state_s   = ST_IDLE;
        balance_s = 11'd0;
        error_s   = 1'b0;
      end
    endcase
  end

  // State, table and output registers; reset reloads every balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_r[i] <= INIT_BALANCE;
      end
      error_r   <= 1'b0;
      balance_r <= 11'd0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      bal_r     <= bal_s;
      error_r   <= error_s;
      balance_r <= balance_s;
    end
  end

  assign error   = error_r;
  assign balance = balance_r;

endmodule

// File: tb/tb_atm.sv
// Table-driven self-checking bench for atm; expectations adapt to ATM_TRANSFER_EN.
module tb_atm;

  logic        clk;
  logic        rst;
  logic        exit;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic [11:0] destinationAccNumber;
  logic [2:0]  menuOption;
  logic [10:0] amount;
  logic        error;
  logic [10:0] balance;

  int errors;
  int checks;

`ifdef ATM_TRANSFER_EN
  localparam bit XF = 1'b1;
`else
  localparam bit XF = 1'b0;
`endif
  // Balance of 2178 and 2816 after the 50-unit transfer (or its absence).
  localparam int A1 = XF ? 350 : 400;
  localparam int A2 = XF ? 550 : 500;

  typedef struct {
    logic        rst;
    logic        ex;
    logic [11:0] acc;
    logic [3:0]  pin;
    logic [11:0] dst;
    logic [2:0]  opt;
    logic [10:0] amt;
    logic        err;
    logic [10:0] bal;
  } vec_t;

  vec_t vecs[$];

  atm #(.INIT_BALANCE(11'd500)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .exit                 (exit),
    .accNumber            (accNumber),
    .pin                  (pin),
    .destinationAccNumber (destinationAccNumber),
    .menuOption           (menuOption),
    .amount               (amount),
    .error                (error),
    .balance              (balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input int acc, input int p, input int dst,
                     input int opt, input int amt, input logic err, input int bal);
    vec_t v;
    v.rst = r; v.ex = e; v.acc = 12'(acc); v.pin = 4'(p); v.dst = 12'(dst);
    v.opt = 3'(opt); v.amt = 11'(amt); v.err = err; v.bal = 11'(bal);
    vecs.push_back(v);
  endtask

  task automatic drive_step(input logic r, input logic e, input int acc, input int p,
                            input int dst, input int opt, input int amt);
    rst = r; exit = e; accNumber = 12'(acc); pin = 4'(p);
    destinationAccNumber = 12'(dst); menuOption = 3'(opt); amount = 11'(amt);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic exp_err, input int exp_bal);
    checks += 2;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %0b expected %0b", name, error, exp_err);
    end
    if (balance !== 11'(exp_bal)) begin
      errors++;
      $display("FAIL %s balance: got %0d expected %0d", name, balance, exp_bal);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0; exit = 1'b0; accNumber = 12'd0; pin = 4'd0;
    destinationAccNumber = 12'd0; menuOption = 3'd0; amount = 11'd0;

    //  rst ex  acc   pin dst   op amt   err   bal
    add(1, 0,    0, 0,    0, 0,    0, 1'b0,   0);
    add(0, 0, 2278, 4,    0, 0,    0, 1'b1,   0);
    add(0, 0, 2178, 5,    0, 0,    0, 1'b1,   0);
    add(0, 0, 2178, 4,    0, 0,    0, 1'b0,   0);
    add(0, 0,    0, 0,    0, 5,  100, 1'b0, 400);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0, 400);
    add(0, 0,    0, 0,    0, 4, 2000, 1'b1, 400);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0, 400);
    add(0, 0,    0, 0, 2816, 6,   50, !XF,  400);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0,  A1);
    add(0, 0,    0, 0, 2816, 6, 2000, 1'b1,  A1);
    add(0, 0,    0, 0, 1234, 6,   10, 1'b1,  A1);
    add(0, 0,    0, 0, 2178, 6,   10, 1'b1,  A1);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0,  A1);
    add(0, 0,    0, 0,    0, 7, 1800, 1'b1,  A1);
    add(0, 0,    0, 0,    0, 7,  500, 1'b0,  A1);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0,  A1 + 500);
    add(0, 0,    0, 0,    0, 1,    0, 1'b0,  A1 + 500);
    add(0, 1,    0, 0,    0, 3,    0, 1'b0,   0);
    add(0, 0, 2816, 6,    0, 3,    0, 1'b0,   0);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0,  A2);
    add(1, 0,    0, 0,    0, 3,    0, 1'b0,   0);
    add(0, 0, 2816, 6,    0, 0,    0, 1'b0,   0);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0, 500);
    // Boundaries: fill 2178 to exactly 2047, then probe overflow paths.
    add(0, 1,    0, 0,    0, 0,    0, 1'b0,   0);
    add(0, 0, 2178, 4,    0, 0,    0, 1'b0,   0);
    add(0, 0,    0, 0,    0, 7, 1547, 1'b0,   0);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0, 2047);
    add(0, 0,    0, 0,    0, 7,    1, 1'b1, 2047);
    add(0, 1,    0, 0,    0, 0,    0, 1'b0,   0);
    add(0, 0, 2816, 6,    0, 0,    0, 1'b0,   0);
    add(0, 0,    0, 0, 2178, 6,    1, 1'b1,   0);
    add(0, 0,    0, 0,    0, 3,    0, 1'b0, 500);
    add(0, 0,    0, 0,    0, 5,  500, 1'b0,   0);
    add(0, 0,    0, 0,    0, 4,    1, 1'b1,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].rst, vecs[i].ex, vecs[i].acc, vecs[i].pin,
                 vecs[i].dst, vecs[i].opt, vecs[i].amt);
      check($sformatf("vec%0d", i), vecs[i].err, vecs[i].bal);
    end

    // Held WITHDRAW re-executes on every edge until funds run out.
    drive_step(1, 0, 0, 0, 0, 0, 0);
    drive_step(0, 0, 2419, 9, 0, 0, 0);
    check("login2419", 1'b0, 0);
    drive_step(0, 0, 0, 0, 0, 4, 200);
    check("hold_wd1", 1'b0, 0);
    drive_step(0, 0, 0, 0, 0, 4, 200);
    check("hold_wd2", 1'b0, 0);
    drive_step(0, 0, 0, 0, 0, 4, 200);
    check("hold_wd3", 1'b1, 0);
    drive_step(0, 0, 0, 0, 0, 3, 0);
    check("hold_bal", 1'b0, 100);

    // Exit wins over a pending withdraw; login works on the very next edge.
    drive_step(0, 1, 0, 0, 0, 4, 50);
    check("exit_prio", 1'b0, 0);
    drive_step(0, 0, 2419, 9, 0, 0, 0);
    check("relogin", 1'b0, 0);
    drive_step(0, 0, 0, 0, 0, 3, 0);
    check("exit_bal", 1'b0, 100);

    // Account 3050 was untouched since reset.
    drive_step(0, 1, 0, 0, 0, 0, 0);
    drive_step(0, 0, 3050, 3, 0, 3, 0);
    check("login3050", 1'b0, 0);
    drive_step(0, 0, 0, 0, 0, 3, 0);
    check("bal3050", 1'b0, 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
